// File: rtl/pool_frame_sequencer.sv
// Round-robin frame sequencer sharing one binary 2x2 max-pool stage among NUM_CH channels.
// Grants a whole frame to one channel, clears the pool stage, forwards pixels, tags and counts
// pooled results, and releases the grant after the last result of the frame.
// Optional drain watchdog: define POOL_SEQ_TIMEOUT_EN to enable DRAIN_TIMEOUT and sticky err.
module pool_frame_sequencer #(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned IN_WIDTH      = 26,
   parameter int unsigned IN_HEIGHT     = 26,
   parameter int unsigned CH_W          = $clog2(NUM_CH),
   parameter int unsigned DRAIN_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_req,
   input  logic [NUM_CH-1:0] ch_valid,
   input  logic [NUM_CH-1:0] ch_pixel,
   output logic [NUM_CH-1:0] ch_ready,
   output logic              pool_reset,
   output logic              pool_valid,
   output logic              pool_pixel,
   input  logic              pool_valid_out,
   input  logic              pool_pixel_out,
   output logic              out_valid,
   output logic              out_pixel,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_last,
   output logic              frame_done,
   output logic              busy,
   output logic              err
);

   localparam int unsigned NumPix = IN_WIDTH * IN_HEIGHT;
   localparam int unsigned NumRes = (IN_WIDTH / 2) * (IN_HEIGHT / 2);
   localparam int unsigned PixW   = $clog2(NumPix + 1);
   localparam int unsigned ResW   = $clog2(NumRes + 1);

   localparam logic [PixW-1:0] PixLast  = PixW'(NumPix - 1);
   localparam logic [ResW-1:0] ResLast  = ResW'(NumRes - 1);
   localparam logic [ResW-1:0] ResFull  = ResW'(NumRes);
   localparam logic [CH_W-1:0] ChMax    = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [CH_W-1:0] grant_q, grant_d;
   logic [CH_W-1:0] last_grant_q, last_grant_d;
   logic            clr_cnt_q, clr_cnt_d;
   logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
   logic [ResW-1:0] res_cnt_q, res_cnt_d;

   logic            rr_found;
   logic [CH_W-1:0] rr_pick;
   logic [CH_W-1:0] rr_idx;
   logic            pix_accept;
   logic            res_accept;
   logic            timeout_hit;

   assign pix_accept = (state_q == StStream) && ch_valid[grant_q];
   // Results are only meaningful while a frame owns the pool stage; a full counter drops extras.
   assign res_accept = ((state_q == StStream) || (state_q == StDrain)) && pool_valid_out &&
                       (res_cnt_q != ResFull);

`ifdef POOL_SEQ_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(DRAIN_TIMEOUT - 1);

   logic [WdW-1:0] wd_q, wd_d;
   logic           err_q;

   // Watchdog: cycles spent in DRAIN since the last pooled result.
   always_comb begin
      wd_d        = '0;
      timeout_hit = 1'b0;
      if ((state_q == StDrain) && !pool_valid_out && (res_cnt_q != ResFull)) begin
         if (wd_q == WdLast) begin
            timeout_hit = 1'b1;
            wd_d        = wd_q;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
   end

   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_q | timeout_hit;
      end
   end

   assign err = err_q;
`else
   logic unused_cfg;

   assign unused_cfg  = ^DRAIN_TIMEOUT;
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // Round-robin search starting one past the last served channel.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_idx   = last_grant_q;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         rr_idx = (rr_idx == ChMax) ? '0 : rr_idx + 1'b1;
         if (!rr_found && ch_req[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx;
         end
      end
   end

   // Next-state logic and frame counters.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      clr_cnt_d    = clr_cnt_q;
      pix_cnt_d    = pix_cnt_q;
      res_cnt_d    = res_cnt_q;

      if (pix_accept) begin
         pix_cnt_d = pix_cnt_q + 1'b1;
      end
      if (res_accept) begin
         res_cnt_d = res_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (rr_found) begin
               grant_d   = rr_pick;
               clr_cnt_d = 1'b0;
               state_d   = StClear;
            end
         end
         StClear: begin
            pix_cnt_d = '0;
            res_cnt_d = '0;
            clr_cnt_d = 1'b1;
            if (clr_cnt_q) begin
               state_d = StStream;
            end
         end
         StStream: begin
            if (pix_accept && (pix_cnt_q == PixLast)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (res_cnt_q == ResFull) begin
               state_d = StDone;
            end else if (timeout_hit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            last_grant_d = grant_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= ChMax;
         clr_cnt_q    <= 1'b0;
         pix_cnt_q    <= '0;
         res_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         clr_cnt_q    <= clr_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         res_cnt_q    <= res_cnt_d;
      end
   end

   // Combinational handshake and status outputs; reset forces them to their idle values at once.
   always_comb begin
      ch_ready   = '0;
      pool_valid = 1'b0;
      pool_pixel = 1'b0;
      pool_reset = !reset;
      frame_done = 1'b0;
      busy       = 1'b0;
      if (reset) begin
         busy = (state_q != StIdle);
         unique case (state_q)
            StClear: pool_reset = 1'b1;
            StStream: begin
               ch_ready[grant_q] = 1'b1;
               pool_valid        = ch_valid[grant_q];
               pool_pixel        = ch_pixel[grant_q];
            end
            StDone:  frame_done = 1'b1;
            default: ;
         endcase
      end
   end

   // Registered, channel-tagged result path.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_pixel <= 1'b0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= res_accept;
         out_last  <= res_accept && (res_cnt_q == ResLast);
         if (res_accept) begin
            out_pixel <= pool_pixel_out;
            out_ch    <= grant_q;
         end
      end
   end

endmodule

// File: tb/tb_pool_frame_sequencer.sv
// Scoreboard bench for pool_frame_sequencer with a registered behavioural 2x2 pool stage.
module tb_pool_frame_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ch_req, ch_valid, ch_pixel, ch_ready;
   logic       pool_reset, pool_valid, pool_pixel;
   logic       pool_valid_out = 1'b0;
   logic       pool_pixel_out = 1'b0;
   logic       out_valid, out_pixel, out_last, frame_done, busy, err;
   logic [1:0] out_ch;

   typedef struct packed {
      logic       pix;
      logic [1:0] ch;
      logic       last;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   acc_mon = 0;
   int   pr_mon = 0;
   bit   withhold_last = 1'b0;
   logic prev_last = 1'b0;

   always #5 clk = ~clk;

   pool_frame_sequencer #(
      .NUM_CH        (4),
      .IN_WIDTH      (4),
      .IN_HEIGHT     (4),
      .CH_W          (2),
      .DRAIN_TIMEOUT (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ch_req         (ch_req),
      .ch_valid       (ch_valid),
      .ch_pixel       (ch_pixel),
      .ch_ready       (ch_ready),
      .pool_reset     (pool_reset),
      .pool_valid     (pool_valid),
      .pool_pixel     (pool_pixel),
      .pool_valid_out (pool_valid_out),
      .pool_pixel_out (pool_pixel_out),
      .out_valid      (out_valid),
      .out_pixel      (out_pixel),
      .out_ch         (out_ch),
      .out_last       (out_last),
      .frame_done     (frame_done),
      .busy           (busy),
      .err            (err)
   );

   // Behavioural 4x4 binary max-pool, one cycle of latency, optional withheld final result.
   logic [1:0] m_col = '0, m_row = '0, m_acc = '0;
   int         m_nres = 0;

   always @(posedge clk) begin
      pool_valid_out <= 1'b0;
      if (pool_reset) begin
         m_col  <= '0;
         m_row  <= '0;
         m_acc  <= '0;
         m_nres <= 0;
      end else if (pool_valid) begin
         if (m_row[0] && m_col[0]) begin
            pool_valid_out     <= !(withhold_last && (m_nres == 3));
            pool_pixel_out     <= m_acc[m_col[1]] | pool_pixel;
            m_acc[m_col[1]]    <= 1'b0;
            m_nres             <= m_nres + 1;
         end else begin
            m_acc[m_col[1]] <= m_acc[m_col[1]] | pool_pixel;
         end
         m_col <= m_col + 2'd1;
         if (m_col == 2'd3) m_row <= m_row + 2'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   // Monitor: accept/clear counting, result scoreboard, frame_done timing.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         acc_mon += $countones(ch_valid & ch_ready);
         if (pool_reset) pr_mon++;
         if (prev_last || (frame_done && !withhold_last))
            chk("done_follows_last", 32'(frame_done), 32'(prev_last));
         prev_last = out_last;
         if (out_valid) begin
            chk("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("result_pix_ch_last", 32'({out_pixel, out_ch, out_last}), 32'(e));
            end
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_ch_ready", 32'(ch_ready), 0);
      chk("rst_pool_valid", 32'(pool_valid), 0);
      chk("rst_pool_pixel", 32'(pool_pixel), 0);
      chk("rst_pool_reset", 32'(pool_reset), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_pixel", 32'(out_pixel), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
   endtask

   // One frame for expected channel ch; exp_res[k] is the hand-computed k-th pooled bit.
   task automatic run_frame(input logic [3:0] req, input int ch, input logic [15:0] pat,
                            input logic [3:0] exp_res, input bit gap, input int drop_after,
                            input int abort_after, input bit check_lat, input bit withhold);
      int         acc;
      int         cyc;
      int         lat;
      bit         done;
      logic [3:0] sel;
      res_t       r;
      sel           = 4'(1 << ch);
      withhold_last = withhold;
      for (int k = 0; k < 4; k++) begin
         if (!(withhold && k == 3)) begin
            r.pix  = exp_res[k];
            r.ch   = 2'(ch);
            r.last = (k == 3);
            exp_q.push_back(r);
         end
      end
      acc_mon = 0;
      pr_mon  = 0;
      ch_req  = req;
      lat     = 0;
      while (ch_ready == 4'b0 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("grant_seen", 32'(ch_ready != 4'b0), 1);
      if (ch_ready == 4'b0) begin
         ch_req = '0;
         exp_q.delete();
         return;
      end
      if (check_lat) chk("req_to_ready_cycles", 32'(lat), 3);
      acc = 0;
      cyc = 0;
      while (acc < 16 && cyc < 100 && !(abort_after != 0 && acc == abort_after)) begin
         chk("ready_onehot", 32'(ch_ready), 32'(sel));
         if (gap && (cyc % 2 == 1)) begin
            ch_valid = ~sel;
            ch_pixel = 4'hF;
         end else begin
            ch_valid = 4'hF;
            ch_pixel = pat[acc] ? sel : ~sel;
         end
         if (ch_valid[ch] && ch_ready[ch]) acc++;
         if (drop_after != 0 && acc == drop_after) ch_req = '0;
         @(posedge clk); #1;
         cyc++;
      end
      chk("pixels_fed", 32'(acc), (abort_after != 0) ? 32'(abort_after) : 32'd16);
      if (abort_after != 0) begin
         reset    = 1'b0;
         ch_valid = '0;
         @(posedge clk); #1;
         check_reset_vals();
         exp_q.delete();
         reset  = 1'b1;
         ch_req = '0;
         return;
      end
      // Keep every channel valid so any extra accept would show up in the monitor count.
      ch_valid = 4'hF;
      ch_pixel = 4'h0;
      cyc      = 0;
      done     = 1'b0;
      while (!done && cyc < 40) begin
         if (frame_done) done = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk("accepts", 32'(acc_mon), 16);
      if (withhold) begin
`ifdef POOL_SEQ_TIMEOUT_EN
         chk("timeout_done", 32'(done), 1);
         chk("timeout_err", 32'(err), 1);
         chk("timeout_drain_cycles", 32'(cyc), 8);
         chk("timeout_results_left", 32'(exp_q.size()), 0);
`else
         chk("no_timeout_done", 32'(done), 0);
         chk("no_timeout_busy", 32'(busy), 1);
         chk("no_timeout_err", 32'(err), 0);
`endif
         ch_valid = '0;
         ch_req   = '0;
         reset    = 1'b0;
         @(posedge clk); #1;
         exp_q.delete();
         reset = 1'b1;
      end else begin
         chk("frame_done_seen", 32'(done), 1);
         chk("pool_reset_cycles", 32'(pr_mon), 2);
         chk("results_left", 32'(exp_q.size()), 0);
         ch_valid = '0;
         ch_req   = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired, want finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      reset    = 1'b0;
      ch_req   = '0;
      ch_valid = '0;
      ch_pixel = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      reset = 1'b1;
      @(posedge clk); #1;

      // Single all-ones frame on ch0, with request-to-ready latency.
      run_frame(4'b0001, 0, 16'hFFFF, 4'b1111, 1'b0, 0, 0, 1'b1, 1'b0);
      // Valid gaps on ch3; blocks 0 and 2 contain a one.
      run_frame(4'b1000, 3, 16'h1020, 4'b0101, 1'b1, 0, 0, 1'b0, 1'b0);
      // All channels requesting: grant order 0,1,2,3,0.
      run_frame(4'b1111, 0, 16'h0000, 4'b0000, 1'b0, 0, 0, 1'b0, 1'b0);
      run_frame(4'b1111, 1, 16'h8000, 4'b1000, 1'b0, 0, 0, 1'b0, 1'b0);
      run_frame(4'b1111, 2, 16'h0001, 4'b0001, 1'b0, 0, 0, 1'b0, 1'b0);
      run_frame(4'b1111, 3, 16'h00C0, 4'b0010, 1'b0, 0, 0, 1'b0, 1'b0);
      run_frame(4'b1111, 0, 16'h0F0F, 4'b1111, 1'b0, 0, 0, 1'b0, 1'b0);
      // Request dropped after 3 pixels; grant holds.
      run_frame(4'b0010, 1, 16'h0300, 4'b0100, 1'b0, 3, 0, 1'b0, 1'b0);
      // Reset after 7 pixels on ch3, then ch2 is granted.
      run_frame(4'b1000, 3, 16'hFFFF, 4'b1111, 1'b0, 0, 7, 1'b0, 1'b0);
      run_frame(4'b0100, 2, 16'h4400, 4'b1000, 1'b0, 0, 0, 1'b0, 1'b0);
      // Final result withheld by the pool stage.
      run_frame(4'b0001, 0, 16'hFFFF, 4'b1111, 1'b0, 0, 0, 1'b0, 1'b1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pool_frame_sequencer.md
# pool_frame_sequencer

Round-robin scheduler that time-shares the single binary 2x2 max-pool stage between NUM_CH binary feature-map channels. It grants one requesting channel a whole IN_WIDTH x IN_HEIGHT frame. It clears the pool stage's internal counters before each frame, forwards the pixel stream, and counts the pooled results. Each result is tagged with its channel id, and the grant is released only after the last pooled pixel returns. It sits between the binary convolution channel outputs and the pool stage.

## Interface
- NUM_CH, 4, number of requesting channels (2..16)
- IN_WIDTH, 26, frame width in pixels (even, >= 2)
- IN_HEIGHT, 26, frame height in pixels (even, >= 2)
- CH_W, $clog2(NUM_CH), channel-id width
- DRAIN_TIMEOUT, 64, watchdog limit in cycles (used only with the macro)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- ch_req  in  NUM_CH  channel has a full frame pending
- ch_valid  in  NUM_CH  channel pixel valid
- ch_pixel  in  NUM_CH  channel binary pixel
- ch_ready  out  NUM_CH  pixel accepted this cycle (one-hot or zero)
- pool_reset  out  1  active-high clear to pool stage
- pool_valid  out  1  pixel valid to pool stage
- pool_pixel  out  1  pixel to pool stage
- pool_valid_out  in  1  pooled result valid from pool stage
- pool_pixel_out  in  1  pooled result from pool stage
- out_valid  out  1  tagged pooled result valid
- out_pixel  out  1  pooled result
- out_ch  out  CH_W  channel id of result
- out_last  out  1  last pooled result of frame
- frame_done  out  1  one-cycle pulse at frame completion
- busy  out  1  state != IDLE
- err  out  1  sticky drain-timeout flag (constant 0 without macro)

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: if any ch_req bit is set, pick a grant `g` by round-robin. Search starts at last_grant+1 and wraps modulo NUM_CH. After reset, last_grant = NUM_CH-1, so channel 0 wins first. Latch g and go to CLEAR.
- CLEAR: pool_reset=1 for exactly 2 cycles, then go to STREAM. Clear the pixel and result counters.
- STREAM:
  - ch_ready[g] = 1 and all other ready bits are 0.
  - A pixel is accepted when ch_valid[g] & ch_ready[g].
  - pool_valid = ch_valid[g] and pool_pixel = ch_pixel[g], both combinational.
  - The pixel counter counts accepted pixels. When the counter reaches IN_WIDTH*IN_HEIGHT, go to DRAIN.
  - ch_valid gaps are allowed. ch_req[g] dropping mid-frame is ignored, and the grant holds.
- DRAIN: ch_ready = 0 and pool_valid = 0. Wait until the result counter reaches (IN_WIDTH/2)*(IN_HEIGHT/2), then go to DONE.
- Result counting is active in STREAM and DRAIN. Each pool_valid_out increments the result counter. Results arriving during STREAM are also counted.
- DONE: frame_done = 1 for one cycle, last_grant <= g, then go to IDLE. The next arbitration happens in the IDLE cycle that follows.
- Result path (registered): out_valid <= pool_valid_out while in STREAM or DRAIN. Alongside it, out_pixel <= pool_pixel_out and out_ch <= g. out_last = 1 on the result that brings the counter to its final value.
- pool_valid_out seen in IDLE, CLEAR or DONE is dropped.
- Counter widths are $clog2(IN_WIDTH*IN_HEIGHT+1) and $clog2(W*H/4+1); neither counter wraps.

## Timing
- Reset values (reset low): state=IDLE, last_grant=NUM_CH-1, ch_ready=0, pool_valid=0, pool_pixel=0, pool_reset=1, out_valid=0, out_pixel=0, out_ch=0, out_last=0, frame_done=0, busy=0, err=0.
- Reset mid-frame aborts the frame. pool_reset stays high while reset is low. Partial results are discarded.
- Minimum latency from a request seen in IDLE to the first ch_ready:
  - 1 cycle IDLE to CLEAR, plus 2 cycles in CLEAR.
  - ch_ready is high in the first STREAM cycle, which is 3 cycles after the request.
- Result latency is 1 cycle from pool_valid_out to out_valid.
- The frame_done pulse comes 1 cycle after out_last.
- Simultaneous requests are resolved strictly round-robin. A single requester may be re-granted back-to-back, with one IDLE cycle in between.

## Configuration
- POOL_SEQ_TIMEOUT_EN defined:
  - A watchdog counts cycles in DRAIN since the last pool_valid_out.
  - When it reaches DRAIN_TIMEOUT, err sets (sticky until reset) and the state goes to DONE. frame_done pulses and out_last is not asserted.
- Not defined: no watchdog; DRAIN waits indefinitely; err tied to 0.

## Test plan
Bench configuration: NUM_CH=4, IN_WIDTH=4, IN_HEIGHT=4, a behavioural pool stage model, and a frame of 16 pixels giving 4 results.
- Single frame: ch_req=0001 with an all-ones frame.
  - pool_reset is high for 2 cycles.
  - Exactly 16 ch_ready[0] accepts occur.
  - 4 out_valid are produced, all with out_pixel=1 and out_ch=0, the 4th with out_last=1.
  - frame_done follows 1 cycle later.
- Round-robin: ch_req=1111 held. The grant order is 0,1,2,3,0. Each frame yields exactly 4 results tagged with the granted channel.
- Backpressure gaps: ch_valid[g] toggles every other cycle. Exactly 16 pixels are still accepted, and the result values match the model's OR of each 2x2 block.
- Reset mid-STREAM: reset goes low after 7 pixels. Next cycle all outputs hold reset values. After release, ch_req=0100 grants ch2 first.
- Timeout (macro defined, DRAIN_TIMEOUT=8): the model withholds its last result. err=1 and frame_done pulse after 8 DRAIN cycles with no result, out_last never asserted. Without the macro, busy stays 1.
- Late request drop: ch_req[1] is deasserted after 3 pixels. The grant holds, and the frame completes with 4 results tagged out_ch=1.
